// File: rtl/pipelined_carry_adder_pkg.sv
// adder_pkg: shared mode encodings and stage-count helper for the pipelined adder
package adder_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  function automatic int calc_stages(input int width, input int seg);
    return width / seg;
  endfunction
endpackage

// File: rtl/adder_segment.sv
// adder_segment: combinational SEG-bit ripple of full adders
module adder_segment #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
);
  logic [SEG:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < SEG; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = ((a[i] ^ b[i]) & c[i]) | (a[i] & b[i]);
  end
  assign co = c[SEG];
endmodule

// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder: WIDTH-bit add/sub split into SEG-bit ripple stages with registered carries
module pipelined_carry_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int STAGES = calc_stages(WIDTH, SEG);
  if (SEG < 1) begin : g_err_seg
    $error("pipelined_carry_adder: SEG must be at least 1");
  end else if (WIDTH % SEG != 0) begin : g_err_width
    $error("pipelined_carry_adder: WIDTH must be a multiple of SEG");
  end
  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam logic [WIDTH-1:0] M = WIDTH'({SEG{1'b1}}) << (k * SEG);
    logic [WIDTH-1:0] ia, ib, xs, ns, ra, rb, rs;
    logic [SEG-1:0]   ss;
    logic             ic, iv, sc, rc, rv;
    if (k == 0) begin : g_in
      // subtraction is A + ~B + ~borrow
      assign ia = a;
      assign ib = (sub == OP_SUB) ? ~b : b;
      assign ic = (sub == OP_SUB) ? ~cin : cin;
      assign xs = '0;
      assign iv = in_valid;
    end else begin : g_mid
      assign ia = g_st[k-1].ra;
      assign ib = g_st[k-1].rb;
      assign ic = g_st[k-1].rc;
      assign xs = g_st[k-1].rs;
      assign iv = g_st[k-1].rv;
    end
    adder_segment #(.SEG(SEG)) u_seg (
      .a (ia[k*SEG +: SEG]),
      .b (ib[k*SEG +: SEG]),
      .ci(ic),
      .s (ss),
      .co(sc)
    );
    assign ns = (xs & ~M) | (WIDTH'(ss) << (k * SEG));
    // data only loads with a valid beat so bubbles leave the outputs untouched
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rv <= 1'b0;
        ra <= '0;
        rb <= '0;
        rs <= '0;
        rc <= 1'b0;
      end else if (!stall) begin
        rv <= iv;
        if (iv) begin
          ra <= ia;
          rb <= ib;
          rs <= ns;
          rc <= sc;
        end
      end
    end
  end
  assign out_valid = g_st[STAGES-1].rv;
  assign sum       = g_st[STAGES-1].rs;
  assign cout      = g_st[STAGES-1].rc;
  assign ovf       = (g_st[STAGES-1].ra[WIDTH-1] == g_st[STAGES-1].rb[WIDTH-1]) &&
                     (g_st[STAGES-1].rs[WIDTH-1] != g_st[STAGES-1].ra[WIDTH-1]);
endmodule
